// File: rtl/riscv_pkg.sv
// Shared types for the core/memory glue: arbiter FSM states and transaction owner.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, data) onto a single-outstanding memory port.
// Data has priority unless it has starved a pending fetch MAX_DATA_STREAK times in a row.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [XLEN-1:0]     if_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [XLEN-1:0]     d_wdata,
    input  logic [XLEN/8-1:0]   d_wstrb,
    output logic                d_resp_valid,
    output logic [XLEN-1:0]     d_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    arb_state_t          state_q, state_d;
    logic [SW-1:0]       streak_q, streak_d;
    owner_t              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN/8-1:0]   wstrb_q;
    logic                if_resp_valid_q, d_resp_valid_q;
    logic [XLEN-1:0]     if_rdata_q, d_rdata_q;
    logic                d_win, if_win, resp_done;

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        d_win         = 1'b0;
        if_win        = 1'b0;
        resp_done     = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is only offered to the winner, so win == accept.
                d_win  = d_req_valid && !(if_req_valid && streak_q == STREAK_MAX);
                if_win = if_req_valid && !d_win;
                if (d_win) begin
                    state_d = ISSUE;
                    if (if_req_valid && streak_q != STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (if_win) begin
                    state_d  = ISSUE;
                    streak_d = '0;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        d_req_ready  = d_win;
        if_req_ready = if_win;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            streak_q        <= '0;
            owner_q         <= OWN_IF;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            if_rdata_q      <= '0;
            d_rdata_q       <= '0;
        end else begin
            state_q         <= state_d;
            streak_q        <= streak_d;
            if_resp_valid_q <= resp_done && (owner_q == OWN_IF);
            d_resp_valid_q  <= resp_done && (owner_q == OWN_D);
            if (d_win) begin
                owner_q <= OWN_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
                wstrb_q <= d_wstrb;
            end else if (if_win) begin
                owner_q <= OWN_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
            if (resp_done) begin
                if (owner_q == OWN_D) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign if_resp_valid = if_resp_valid_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int MAXS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0]       if_addr, if_rdata;
    logic              d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [63:0]       d_addr, d_wdata, d_rdata;
    logic [7:0]        d_wstrb;
    logic              mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [63:0]       mem_addr, mem_wdata, mem_rdata;
    logic [7:0]        mem_wstrb;

    always #5 clk = ~clk;

    mem_arbiter #(
        .XLEN            (XLEN),
        .ADDR_W          (ADDR_W),
        .MAX_DATA_STREAK (MAXS)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_addr         (d_addr),
        .d_we           (d_we),
        .d_wdata        (d_wdata),
        .d_wstrb        (d_wstrb),
        .d_resp_valid   (d_resp_valid),
        .d_rdata        (d_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: one transaction in flight, described by flags rather than states.
    bit          busy, issued, own_d, pend_if, pend_d;
    int          streak;
    logic [63:0] m_addr, m_wdata, last_if, last_d;
    bit          m_we;
    logic [7:0]  m_wstrb;
    bit          grant_log[$];  // 1 = data, 0 = fetch
    bit          resp_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; issued = 0; own_d = 0; pend_if = 0; pend_d = 0; streak = 0;
        m_addr = '0; m_we = 0; m_wdata = '0; m_wstrb = '0; last_if = '0; last_d = '0;
    endtask

    task automatic step(input bit rst_v, input bit ifv, input logic [63:0] ifa,
                        input bit dv, input logic [63:0] da, input bit dwe,
                        input logic [63:0] dwd, input logic [7:0] dws,
                        input bit mrdy, input bit mrv, input logic [63:0] mrd);
        bit exp_d_rdy, exp_if_rdy, nxt_if, nxt_d;
        @(negedge clk);
        reset = rst_v; if_req_valid = ifv; if_addr = ifa;
        d_req_valid = dv; d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dws;
        mem_req_ready = mrdy; mem_resp_valid = mrv; mem_rdata = mrd;
        if (rst_v) model_reset();
        #2;
        exp_d_rdy  = !busy && dv && !(ifv && streak == MAXS);
        exp_if_rdy = !busy && ifv && !exp_d_rdy;
        check_eq("d_req_ready", d_req_ready, exp_d_rdy);
        check_eq("if_req_ready", if_req_ready, exp_if_rdy);
        check_eq("mem_req_valid", mem_req_valid, busy && !issued);
        if (busy && !issued) begin
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_we", mem_we, m_we);
            check_eq("mem_wstrb", mem_wstrb, m_wstrb);
            if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        end
        if (rst_v) check_eq("reset_mem_addr", mem_addr, 0);
        check_eq("if_resp_valid", if_resp_valid, pend_if);
        check_eq("d_resp_valid", d_resp_valid, pend_d);
        check_eq("if_rdata", if_rdata, last_if);
        check_eq("d_rdata", d_rdata, last_d);
        if (d_req_valid && d_req_ready) grant_log.push_back(1'b1);
        else if (if_req_valid && if_req_ready) grant_log.push_back(1'b0);
        if (d_resp_valid) resp_log.push_back(1'b1);
        if (if_resp_valid) resp_log.push_back(1'b0);
        if (!rst_v) begin
            nxt_if = 0; nxt_d = 0;
            if (!busy) begin
                if (exp_d_rdy) begin
                    busy = 1; issued = 0; own_d = 1;
                    m_addr = da; m_we = dwe; m_wdata = dwd; m_wstrb = dws;
                    if (ifv && streak < MAXS) streak++;
                end else if (exp_if_rdy) begin
                    busy = 1; issued = 0; own_d = 0;
                    m_addr = ifa; m_we = 0; m_wdata = '0; m_wstrb = '0;
                    streak = 0;
                end
            end else if (!issued) begin
                if (mrdy) issued = 1;
            end else if (mrv) begin
                busy = 0;
                if (own_d) begin nxt_d = 1; last_d = mrd; end
                else begin nxt_if = 1; last_if = mrd; end
            end
            pend_if = nxt_if; pend_d = nxt_d;
        end
    endtask

    task automatic quiet(input bit mrdy, input bit mrv, input logic [63:0] mrd);
        step(0, 0, '0, 0, '0, 0, '0, '0, mrdy, mrv, mrd);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (busy || pend_if || pend_d); i++) quiet(1, 1, 64'hdead);
    endtask

    initial begin
        bit exp_order[6];
        int lat;
        int pulses;
        reset = 1; if_req_valid = 0; if_addr = '0; d_req_valid = 0; d_addr = '0;
        d_we = 0; d_wdata = '0; d_wstrb = '0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_rdata = '0;
        model_reset();
        step(1, 0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
        step(1, 0, '0, 0, '0, 0, '0, '0, 1, 1, 64'h55);

        // Fetch-only with first-opportunity memory handshakes.
        step(0, 1, 64'h80000000, 0, '0, 0, '0, '0, 0, 0, '0);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            quiet(1, 1, 64'h00a0009300000013);
            if (if_resp_valid && lat == 0) lat = i;
        end
        check_eq("fetch_latency", lat, 3);
        check_eq("fetch_rdata", if_rdata, 64'h00a0009300000013);

        // Simultaneous fetch and data read: data first, then fetch.
        drain();
        resp_log.delete();
        grant_log.delete();
        step(0, 1, 64'h80000008, 1, 64'h80000010, 0, '0, '0, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            step(0, grant_log.size() < 2, 64'h80000008, 0, '0, 0, '0, '0, 1, 1, 64'h1000 + i);
        end
        check_eq("simul_resp_count", resp_log.size(), 2);
        if (resp_log.size() >= 2) begin
            check_eq("simul_first_d", resp_log[0], 1);
            check_eq("simul_second_if", resp_log[1], 0);
        end

        // Starvation: both valid continuously from a cleared streak.
        step(1, 0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
        grant_log.delete();
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 64'h80000100 + i, 1, 64'h80000200 + i, 0, '0, '0, 1, 1, $urandom);
        end
        exp_order = '{1, 1, 1, 1, 0, 1};
        check_eq("starve_count", grant_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check_eq("starve_grant", grant_log[i], exp_order[i]);
        end

        // Write with memory ready delayed five cycles.
        drain();
        step(0, 0, '0, 1, 64'h80000018, 1, 64'h1122334455667788, 8'h0f, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            quiet(0, 1, 64'h77);
            check_eq("wr_valid_held", mem_req_valid, 1);
            check_eq("wr_addr_held", mem_addr, 64'h80000018);
            check_eq("wr_data_held", mem_wdata, 64'h1122334455667788);
            check_eq("wr_strb_held", mem_wstrb, 8'h0f);
            check_eq("wr_we_held", mem_we, 1);
        end
        quiet(1, 0, '0);
        quiet(0, 1, 64'h99);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            quiet(0, 0, '0);
            if (d_resp_valid) pulses++;
        end
        check_eq("wr_ack_pulses", pulses, 1);

        // Reset while waiting for the memory response.
        step(0, 1, 64'h80000040, 0, '0, 0, '0, '0, 0, 0, '0);
        quiet(1, 0, '0);
        step(1, 0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
        quiet(0, 1, 64'hbad);
        quiet(0, 0, '0);
        check_eq("rst_wait_if_resp", if_resp_valid, 0);
        check_eq("rst_wait_d_resp", d_resp_valid, 0);
        check_eq("rst_wait_mem_valid", mem_req_valid, 0);

        // Stray responses while idle.
        for (int i = 0; i < 3; i++) quiet(1, 1, 64'hbeef);
        check_eq("stray_if_resp", if_resp_valid, 0);
        check_eq("stray_d_resp", d_resp_valid, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1, 0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
            end else begin
                step(0, $urandom_range(0, 2) != 0, {32'h8000_0000, $urandom},
                     $urandom_range(0, 2) != 0, {$urandom, $urandom}, 1'($urandom),
                     {$urandom, $urandom}, 8'($urandom),
                     1'($urandom), 1'($urandom), {$urandom, $urandom});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, address width in bits.
REQ-003 SHALL have parameter MAX_DATA_STREAK, default 4, the maximum number of consecutive data grants allowed while fetch is pending.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be rising-edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have fetch request ports: if_req_valid in 1, if_req_ready out 1, if_addr in ADDR_W.
REQ-007 SHALL have fetch response ports: if_resp_valid out 1, if_rdata out XLEN.
REQ-008 SHALL have data request ports: d_req_valid in 1, d_req_ready out 1, d_addr in ADDR_W, d_we in 1, d_wdata in XLEN, d_wstrb in XLEN/8.
REQ-009 SHALL have data response ports: d_resp_valid out 1, d_rdata out XLEN.
REQ-010 SHALL have memory request ports: mem_req_valid out 1, mem_req_ready in 1, mem_addr out ADDR_W, mem_we out 1, mem_wdata out XLEN, mem_wstrb out XLEN/8.
REQ-011 SHALL have memory response ports: mem_resp_valid in 1, mem_rdata in XLEN.

Function
REQ-012 SHALL implement an FSM with states IDLE, ISSUE and WAIT, and SHALL allow at most one outstanding memory transaction.
REQ-013 SHALL assert if_req_ready/d_req_ready combinationally only in IDLE, and only for the arbitration winner; a request is accepted when valid&ready hold in the same cycle.
REQ-014 SHALL give data priority when both requests are valid, except when data_streak==MAX_DATA_STREAK, in which case fetch SHALL win.
REQ-015 SHALL increment data_streak on a data grant while if_req_valid=1, saturating at MAX_DATA_STREAK, and SHALL clear it on any fetch grant.
REQ-016 SHALL, on acceptance, latch addr/we/wdata/wstrb and owner (fetch forces we=0, wstrb=0) and go to ISSUE next cycle.
REQ-017 SHALL, in ISSUE, hold mem_req_valid=1 with stable latched fields until mem_req_ready=1, then go to WAIT.
REQ-018 SHALL, in WAIT, on mem_resp_valid=1, register mem_rdata into the owner's rdata, pulse the owner's resp_valid for exactly one cycle (the next cycle), and return to IDLE in that same cycle.
REQ-019 SHALL provide a write acknowledge via d_resp_valid; d_rdata is don't-care for writes.
REQ-020 SHALL ignore mem_resp_valid in IDLE and ISSUE.
REQ-021 SHALL have a minimum latency of 3 cycles from accept to resp_valid when mem_req_ready and mem_resp_valid are each asserted on first opportunity.
REQ-022 SHALL hold the non-owner resp_valid at 0 at all times, and SHALL leave rdata outputs held at their last value when resp_valid=0.
REQ-023 SHALL allow a new request to be accepted in the IDLE cycle that coincides with a resp_valid pulse.

Reset
REQ-024 SHALL, while reset=1, asynchronously force state=IDLE, data_streak=0, mem_req_valid=0, and both resp_valid=0, with rdata outputs and latched fields =0.
REQ-025 SHALL, on reset mid-transaction, discard the outstanding transaction without any response, and SHALL ignore a late mem_resp_valid.

Structure
REQ-026 SHALL take the arb_state_t enum (IDLE/ISSUE/WAIT) and the owner_t enum (OWN_IF/OWN_D) from the shared riscv_pkg.
REQ-027 SHALL be a single module with no sub-module; it instantiates between the core pipeline and memory_controller.

Verification
REQ-028 Fetch-only: if_addr=0x80000000, memory returns 0x00a0009300000013 -> if_resp_valid pulses 3 cycles after accept with that data, and d_resp_valid stays 0.
REQ-029 Simultaneous: fetch 0x80000008 and data read 0x80000010 valid in the same cycle -> data granted first, fetch granted in the next IDLE, with responses in order data then fetch.
REQ-030 Starvation: d_req_valid and if_req_valid held high continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,...
REQ-031 Write: d_we=1, d_addr=0x80000018, d_wdata=0x1122334455667788, d_wstrb=0x0F, mem_req_ready delayed 5 cycles -> mem fields stable for all 5 cycles, then one d_resp_valid.
REQ-032 Reset in WAIT: reset pulse, then mem_resp_valid=1 -> no resp_valid, state IDLE, mem_req_valid=0.
REQ-033 Stray response: mem_resp_valid=1 in IDLE -> both resp_valid remain 0.
